// File: rtl/hamming_secded_serial_codec.sv
// hamming_secded_serial_codec
//   Extended-Hamming (SECDED) codec built around one shared shift register and
//   bit counter. Per frame it either encodes a parallel word into a serial
//   codeword (bit 0 first) or decodes a serial codeword into a corrected
//   parallel word with single-error correction and double-error detection.
//
//   Codeword layout: bit 0 is overall parity (all bits XOR to 0). Bits
//   1..CW_W-1 are Hamming positions; parity bits sit at powers of two and
//   data bits fill the remaining positions in ascending order.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   mode           0 = encode, 1 = decode (sampled in IDLE only)
//   flush          synchronous abort back to IDLE, frame discarded
//   in_valid/in_ready/in_data         encode parallel input handshake
//   ser_out/ser_out_vld/ser_out_last  encode serial output
//   ser_in/ser_in_vld                 decode serial input (gaps allowed)
//   busy                              engine is not in IDLE
//   dec_data/dec_valid/err_corr/err_uncorr/syndrome  decode result
//
// State        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | waiting for encode handshake or first decode bit
// S_ENC_SHIFT  | driving codeword bits on ser_out, one per cycle
// S_DEC_SHIFT  | collecting codeword bits on ser_in_vld cycles
// S_DEC_FIX    | registering syndrome and overall parity
// S_DEC_OUT    | applying correction, registering result and strobe
module hamming_secded_serial_codec #(
  parameter int DATA_W = 11,
  parameter int PAR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_out,
  output logic              ser_out_vld,
  output logic              ser_out_last,
  input  logic              ser_in,
  input  logic              ser_in_vld,
  output logic              busy,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_valid,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [PAR_W-1:0]  syndrome
);

  localparam int CW_W     = DATA_W + PAR_W + 1;
  localparam int CNT_W    = (CW_W > 2) ? $clog2(CW_W) : 1;
  localparam int SYN_SPAN = 2 ** PAR_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW_W - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(CW_W - 2);

  if (SYN_SPAN < CW_W) begin : g_bad_par_w
    $error("PAR_W too small: 2**PAR_W must be >= DATA_W+PAR_W+1");
  end
  // Every parity position must land inside the codeword, otherwise the
  // data-to-position mapping runs out of slots.
  if (2 ** (PAR_W - 1) > CW_W - 1) begin : g_bad_par_fit
    $error("PAR_W too large for DATA_W: parity positions exceed codeword");
  end

  // Codeword position of data bit j (j-th non-power-of-two position >= 1).
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == j) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Positions covered by parity bit k (position index has bit k set).
  function automatic logic [CW_W-1:0] par_mask(input int k);
    logic [CW_W-1:0] m;
    m = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (((i >> k) & 1) != 0) m = m | (CW_W'(1) << i);
    end
    return m;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC_SHIFT,
    S_DEC_SHIFT,
    S_DEC_FIX,
    S_DEC_OUT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CW_W-1:0]    sr;
  logic [PAR_W-1:0]   syn_r;
  logic               q_r;

  // ---------------- encoder datapath ----------------
  logic [CW_W-1:0]    enc_place [DATA_W+1];
  logic [CW_W-1:0]    enc_par   [PAR_W+1];
  logic [PAR_W-1:0]   enc_syn;
  logic [CW_W-1:0]    enc_cw;

  assign enc_place[0] = '0;
  for (genvar j = 0; j < DATA_W; j++) begin : g_enc_place
    localparam int P = data_pos(j);
    assign enc_place[j+1] = enc_place[j] | (CW_W'(in_data[j]) << P);
  end

  // With parity positions still zero, the syndrome of the data-only word is
  // exactly the parity value each power-of-two position needs.
  assign enc_par[0] = enc_place[DATA_W];
  for (genvar k = 0; k < PAR_W; k++) begin : g_enc_par
    assign enc_syn[k]   = ^(enc_place[DATA_W] & par_mask(k));
    assign enc_par[k+1] = enc_par[k] | (CW_W'(enc_syn[k]) << (1 << k));
  end

  assign enc_cw = {enc_par[PAR_W][CW_W-1:1], ^enc_par[PAR_W][CW_W-1:1]};

  // ---------------- decoder datapath ----------------
  logic [PAR_W-1:0]    dec_syn;
  logic [SYN_SPAN-1:0] syn_onehot;
  logic                syn_in_range;
  logic [CW_W-1:0]     corr_flip;
  logic                corr_hit;
  logic                uncorr_hit;
  logic [CW_W-1:0]     dec_fixed;
  logic [DATA_W-1:0]   dec_word;

  for (genvar k = 0; k < PAR_W; k++) begin : g_dec_syn
    assign dec_syn[k] = ^(sr & par_mask(k));
  end

  // A syndrome beyond the last real position (shortened code) has no bit
  // to flip; the one-hot decode simply falls off the top in that case.
  assign syn_onehot   = SYN_SPAN'(1) << syn_r;
  assign syn_in_range = |syn_onehot[CW_W-1:0];

  always_comb begin
    corr_flip  = '0;
    corr_hit   = 1'b0;
    uncorr_hit = 1'b0;
    if (q_r) begin
      if (syn_in_range) begin
        corr_flip = syn_onehot[CW_W-1:0];
        corr_hit  = 1'b1;
      end else begin
        uncorr_hit = 1'b1;
      end
    end else if (syn_r != '0) begin
      uncorr_hit = 1'b1;
    end
  end

  assign dec_fixed = sr ^ corr_flip;

  for (genvar j = 0; j < DATA_W; j++) begin : g_dec_extract
    localparam int P = data_pos(j);
    assign dec_word[j] = dec_fixed[P];
  end

  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_IDLE) && !mode;

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sr           <= '0;
      syn_r        <= '0;
      q_r          <= 1'b0;
      ser_out      <= 1'b0;
      ser_out_vld  <= 1'b0;
      ser_out_last <= 1'b0;
      dec_valid    <= 1'b0;
      dec_data     <= '0;
      err_corr     <= 1'b0;
      err_uncorr   <= 1'b0;
      syndrome     <= '0;
    end else begin
      dec_valid <= 1'b0;
      if (flush) begin
        state        <= S_IDLE;
        cnt          <= '0;
        ser_out      <= 1'b0;
        ser_out_vld  <= 1'b0;
        ser_out_last <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt <= '0;
            if (!mode) begin
              if (in_valid) begin
                sr           <= enc_cw >> 1;
                ser_out      <= enc_cw[0];
                ser_out_vld  <= 1'b1;
                ser_out_last <= 1'b0;
                state        <= S_ENC_SHIFT;
              end
            end else if (ser_in_vld) begin
              // Bits enter at the top so bit 0 ends up at sr[0].
              sr    <= {ser_in, sr[CW_W-1:1]};
              cnt   <= CNT_W'(1);
              state <= S_DEC_SHIFT;
            end
          end

          S_ENC_SHIFT: begin
            if (cnt == CNT_LAST) begin
              state        <= S_IDLE;
              cnt          <= '0;
              ser_out      <= 1'b0;
              ser_out_vld  <= 1'b0;
              ser_out_last <= 1'b0;
            end else begin
              ser_out      <= sr[0];
              sr           <= sr >> 1;
              cnt          <= cnt + CNT_W'(1);
              ser_out_last <= (cnt == CNT_PEN);
            end
          end

          S_DEC_SHIFT: begin
            if (ser_in_vld) begin
              sr <= {ser_in, sr[CW_W-1:1]};
              if (cnt == CNT_LAST) begin
                state <= S_DEC_FIX;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end

          S_DEC_FIX: begin
            syn_r <= dec_syn;
            q_r   <= ^sr;
            state <= S_DEC_OUT;
          end

          S_DEC_OUT: begin
            dec_data   <= dec_word;
            err_corr   <= corr_hit;
            err_uncorr <= uncorr_hit;
            syndrome   <= syn_r;
            dec_valid  <= 1'b1;
            cnt        <= '0;
            state      <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
